countdown_ctrl: RTL and testbench

//  Countdown-timer controller for the VGA timer display. Runs in the 25 MHz pixel-clock domain.

---
 rtl/countdown_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_countdown_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// Countdown-timer controller: button edits of a BCD mm:ss value, 1 Hz countdown,
// alarm at 00:00 and restore of the programmed preset.
module countdown_ctrl #(
    parameter int MAX_MIN    = 59,
    parameter int ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [2:0] state,
    output logic       edit_sec,
    output logic       blink,
    output logic       alarm
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET_MIN = 3'd1,
        SET_SEC = 3'd2,
        RUN     = 3'd3,
        PAUSE   = 3'd4,
        ALARM   = 3'd5
    } state_t;

    localparam int          CW          = $clog2(ALARM_SECS + 1);
    localparam logic [7:0]  MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
    localparam logic [7:0]  MAX_SEC_BCD = 8'h59;
    localparam logic [CW-1:0] ALARM_LAST = CW'(ALARM_SECS - 1);

    state_t          cur_state;
    state_t          next_state;
    logic [4:0]      btn_now;
    logic [4:0]      btn_q;
    logic [4:0]      press;
    logic            ev_center;
    logic            ev_left;
    logic            ev_right;
    logic            ev_up;
    logic            ev_down;
    logic            ev_tick;
    logic [7:0]      preset_min;
    logic [7:0]      preset_sec;
    logic [CW-1:0]   alarm_cnt;
    logic [7:0]      run_min;
    logic [7:0]      run_sec;
    logic            run_zero;
    logic            time_zero;
    logic            alarm_done;
    logic [7:0]      nxt_min;
    logic [7:0]      nxt_sec;
    logic [7:0]      nxt_preset_min;
    logic [7:0]      nxt_preset_sec;
    logic [CW-1:0]   nxt_cnt;
    logic            nxt_edit;
    logic            nxt_blink;
    logic            nxt_alarm;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
        if (v == 8'h00)
            return top;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign btn_now = {btn_center, btn_left, btn_right, btn_up, btn_down};
    assign press   = btn_now & ~btn_q;

    // Only the highest-priority event of a cycle survives; the rest are dropped.
    assign ev_center = press[4];
    assign ev_left   = ~press[4] & press[3];
    assign ev_right  = ~press[4] & ~press[3] & press[2];
    assign ev_up     = ~(|press[4:2]) & press[1];
    assign ev_down   = ~(|press[4:1]) & press[0];
    assign ev_tick   = ~(|press) & tick_1hz;

    always_comb begin
        run_min = min_bcd;
        run_sec = bcd_dec(sec_bcd, MAX_SEC_BCD);
        if (sec_bcd == 8'h00)
            run_min = bcd_dec(min_bcd, MAX_MIN_BCD);
    end

    assign run_zero   = (run_min == 8'h00) && (run_sec == 8'h00);
    assign time_zero  = (min_bcd == 8'h00) && (sec_bcd == 8'h00);
    assign alarm_done = ev_tick && (alarm_cnt == ALARM_LAST);
    assign state      = cur_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cur_state <= IDLE;
        else
            cur_state <= next_state;
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            IDLE: begin
                if (ev_center)
                    next_state = SET_MIN;
            end
            SET_MIN, SET_SEC: begin
                if (ev_center && !time_zero)
                    next_state = RUN;
                else if (ev_left)
                    next_state = SET_MIN;
                else if (ev_right)
                    next_state = SET_SEC;
            end
            RUN: begin
                if (ev_center)
                    next_state = PAUSE;
                else if (ev_tick && run_zero)
                    next_state = ALARM;
            end
            PAUSE: begin
                if (ev_center)
                    next_state = RUN;
                else if (ev_left)
                    next_state = SET_MIN;
                else if (ev_right)
                    next_state = SET_SEC;
            end
            ALARM: begin
                if (ev_center || alarm_done)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        nxt_min        = min_bcd;
        nxt_sec        = sec_bcd;
        nxt_preset_min = preset_min;
        nxt_preset_sec = preset_sec;
        nxt_cnt        = alarm_cnt;
        nxt_edit       = edit_sec;
        nxt_blink      = blink;
        nxt_alarm      = alarm;
        case (cur_state)
            SET_MIN: begin
                if (ev_up)
                    nxt_min = bcd_inc(min_bcd, MAX_MIN_BCD);
                else if (ev_down)
                    nxt_min = bcd_dec(min_bcd, MAX_MIN_BCD);
                else if (ev_tick)
                    nxt_blink = ~blink;
            end
            SET_SEC: begin
                if (ev_up)
                    nxt_sec = bcd_inc(sec_bcd, MAX_SEC_BCD);
                else if (ev_down)
                    nxt_sec = bcd_dec(sec_bcd, MAX_SEC_BCD);
                else if (ev_tick)
                    nxt_blink = ~blink;
            end
            RUN: begin
                if (ev_tick) begin
                    nxt_min = run_min;
                    nxt_sec = run_sec;
                end
            end
            ALARM: begin
                if (ev_tick) begin
                    nxt_cnt   = alarm_cnt + CW'(1);
                    nxt_blink = ~blink;
                end
            end
            default: ;
        endcase

        // Entry actions override the per-state updates above.
        if (next_state != cur_state) begin
            case (next_state)
                IDLE: begin
                    nxt_min   = preset_min;
                    nxt_sec   = preset_sec;
                    nxt_alarm = 1'b0;
                    nxt_blink = 1'b0;
                end
                SET_MIN: nxt_edit = 1'b0;
                SET_SEC: nxt_edit = 1'b1;
                RUN: begin
                    nxt_blink = 1'b0;
                    if (cur_state == SET_MIN || cur_state == SET_SEC) begin
                        nxt_preset_min = min_bcd;
                        nxt_preset_sec = sec_bcd;
                    end
                end
                PAUSE: nxt_blink = 1'b0;
                ALARM: begin
                    nxt_alarm = 1'b1;
                    nxt_cnt   = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q      <= '0;
            min_bcd    <= 8'h00;
            sec_bcd    <= 8'h00;
            preset_min <= 8'h00;
            preset_sec <= 8'h00;
            alarm_cnt  <= '0;
            edit_sec   <= 1'b0;
            blink      <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            btn_q      <= btn_now;
            min_bcd    <= nxt_min;
            sec_bcd    <= nxt_sec;
            preset_min <= nxt_preset_min;
            preset_sec <= nxt_preset_sec;
            alarm_cnt  <= nxt_cnt;
            edit_sec   <= nxt_edit;
            blink      <= nxt_blink;
            alarm      <= nxt_alarm;
        end
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: directed scenarios plus random button/tick traffic,
// all checked against a seconds-based behavioural model.
module tb_countdown_ctrl;

    localparam int MAX_MIN    = 59;
    localparam int ALARM_SECS = 10;
    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_C    = 5'b10000;
    localparam logic [4:0] B_L    = 5'b01000;
    localparam logic [4:0] B_R    = 5'b00100;
    localparam logic [4:0] B_U    = 5'b00010;
    localparam logic [4:0] B_D    = 5'b00001;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_center = 1'b0;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic [2:0] state;
    logic       edit_sec;
    logic       blink;
    logic       alarm;
    logic [21:0] dut_vec;

    int n_cmp = 0;
    int n_fail = 0;

    // Model keeps the time as plain integers and the preset as total seconds.
    int   m_state, m_min, m_sec, m_preset, m_acnt;
    logic m_edit, m_blink, m_alarm;
    logic [4:0] m_prev;

    countdown_ctrl #(.MAX_MIN(MAX_MIN), .ALARM_SECS(ALARM_SECS)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_center(btn_center),
        .min_bcd(min_bcd), .sec_bcd(sec_bcd), .state(state),
        .edit_sec(edit_sec), .blink(blink), .alarm(alarm)
    );

    always #20 clk = ~clk;

    assign dut_vec = {state, min_bcd, sec_bcd, edit_sec, blink, alarm};

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [21:0] exp_vec();
        return {3'(m_state), to_bcd(m_min), to_bcd(m_sec), m_edit, m_blink, m_alarm};
    endfunction

    task automatic model_reset();
        m_state = 0; m_min = 0; m_sec = 0; m_preset = 0; m_acnt = 0;
        m_edit = 1'b0; m_blink = 1'b0; m_alarm = 1'b0; m_prev = '0;
    endtask

    task automatic model_go_idle();
        m_state = 0;
        m_min = m_preset / 60;
        m_sec = m_preset % 60;
        m_alarm = 1'b0;
        m_blink = 1'b0;
    endtask

    task automatic model_step(input logic [4:0] b, input logic t);
        logic [4:0] p;
        int ev;
        int total;
        p = b & ~m_prev;
        m_prev = b;
        if (p[4]) ev = 1;
        else if (p[3]) ev = 2;
        else if (p[2]) ev = 3;
        else if (p[1]) ev = 4;
        else if (p[0]) ev = 5;
        else if (t) ev = 6;
        else ev = 0;
        total = m_min * 60 + m_sec;
        case (m_state)
            0: if (ev == 1) begin m_state = 1; m_edit = 1'b0; end
            1, 2: begin
                if (ev == 1) begin
                    if (total != 0) begin m_state = 3; m_preset = total; m_blink = 1'b0; end
                end else if (ev == 2) begin m_state = 1; m_edit = 1'b0; end
                else if (ev == 3) begin m_state = 2; m_edit = 1'b1; end
                else if (ev == 4) begin
                    if (m_state == 1) m_min = (m_min + 1) % (MAX_MIN + 1);
                    else m_sec = (m_sec + 1) % 60;
                end else if (ev == 5) begin
                    if (m_state == 1) m_min = (m_min + MAX_MIN) % (MAX_MIN + 1);
                    else m_sec = (m_sec + 59) % 60;
                end else if (ev == 6) m_blink = ~m_blink;
            end
            3: begin
                if (ev == 1) begin m_state = 4; m_blink = 1'b0; end
                else if (ev == 6) begin
                    total = total - 1;
                    m_min = total / 60;
                    m_sec = total % 60;
                    if (total == 0) begin m_state = 5; m_alarm = 1'b1; m_acnt = 0; end
                end
            end
            4: begin
                if (ev == 1) begin m_state = 3; m_blink = 1'b0; end
                else if (ev == 2) begin m_state = 1; m_edit = 1'b0; end
                else if (ev == 3) begin m_state = 2; m_edit = 1'b1; end
            end
            5: begin
                if (ev == 1) model_go_idle();
                else if (ev == 6) begin
                    m_acnt = m_acnt + 1;
                    if (m_acnt == ALARM_SECS) model_go_idle();
                    else m_blink = ~m_blink;
                end
            end
            default: ;
        endcase
    endtask

    task automatic applyStimulus(input logic [4:0] b, input logic t);
        @(negedge clk);
        {btn_center, btn_left, btn_right, btn_up, btn_down} = b;
        tick_1hz = t;
        @(posedge clk);
        model_step(b, t);
        #1;
    endtask

    task automatic press(input logic [4:0] b);
        applyStimulus(b, 1'b0);
        applyStimulus(B_NONE, 1'b0);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            applyStimulus(B_NONE, 1'b1);
            applyStimulus(B_NONE, 1'b0);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        {btn_center, btn_left, btn_right, btn_up, btn_down} = B_NONE;
        tick_1hz = 1'b0;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Walks to SET_SEC holding mm:ss, using the model to know how many ups are needed.
    task automatic program_time(input int mm, input int ss);
        if (m_state == 0) press(B_C);
        press(B_L);
        repeat ((mm - m_min + MAX_MIN + 1) % (MAX_MIN + 1)) press(B_U);
        press(B_R);
        repeat ((ss - m_sec + 60) % 60) press(B_U);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        {btn_center, btn_left, btn_right, btn_up, btn_down} = 5'b11111;
        tick_1hz = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (dut_vec !== 22'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_hold: got %h expected %h", dut_vec, 22'd0);
        end
        @(negedge clk);
        {btn_center, btn_left, btn_right, btn_up, btn_down} = B_NONE;
        tick_1hz = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(B_NONE, 1'b0);
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("[TB] FAIL reset_release: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_set_min();
        reset_dut();
        press(B_C);
        repeat (3) press(B_U);
        n_cmp++;
        if ({state, min_bcd} !== {3'd1, 8'h03}) begin
            n_fail++;
            $display("[TB] FAIL set_min_up3: got %h expected %h", {state, min_bcd}, {3'd1, 8'h03});
        end
        repeat (4) press(B_D);
        n_cmp++;
        if (min_bcd !== 8'h59) begin
            n_fail++;
            $display("[TB] FAIL set_min_wrap_down: got %h expected %h", min_bcd, 8'h59);
        end
        repeat (1000) applyStimulus(B_U, 1'b0);
        applyStimulus(B_NONE, 1'b0);
        n_cmp++;
        if ({state, min_bcd} !== {3'd1, 8'h00}) begin
            n_fail++;
            $display("[TB] FAIL hold_single_inc: got %h expected %h", {state, min_bcd}, {3'd1, 8'h00});
        end
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("[TB] FAIL set_min_model: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_run();
        reset_dut();
        program_time(1, 0);
        press(B_C);
        n_cmp++;
        if (state !== 3'd3) begin
            n_fail++;
            $display("[TB] FAIL run_enter: got %0d expected %0d", state, 3);
        end
        applyStimulus(B_NONE, 1'b1);
        n_cmp++;
        if ({min_bcd, sec_bcd} !== 16'h0059) begin
            n_fail++;
            $display("[TB] FAIL run_borrow: got %h expected %h", {min_bcd, sec_bcd}, 16'h0059);
        end
        applyStimulus(B_NONE, 1'b0);
        ticks(9);
        n_cmp++;
        if ({state, min_bcd, sec_bcd} !== {3'd3, 16'h0050}) begin
            n_fail++;
            $display("[TB] FAIL run_9_ticks: got %h expected %h", {state, min_bcd, sec_bcd}, {3'd3, 16'h0050});
        end
    endtask

    task automatic test_alarm();
        reset_dut();
        program_time(0, 2);
        press(B_C);
        ticks(2);
        n_cmp++;
        if ({state, alarm, min_bcd, sec_bcd} !== {3'd5, 1'b1, 16'h0000}) begin
            n_fail++;
            $display("[TB] FAIL alarm_enter: got %h expected %h", {state, alarm, min_bcd, sec_bcd}, {3'd5, 1'b1, 16'h0000});
        end
        ticks(ALARM_SECS - 1);
        n_cmp++;
        if ({state, alarm, blink} !== {3'd5, 1'b1, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL alarm_before_end: got %h expected %h", {state, alarm, blink}, {3'd5, 1'b1, 1'b1});
        end
        ticks(1);
        n_cmp++;
        if ({state, alarm, blink, min_bcd, sec_bcd} !== {3'd0, 1'b0, 1'b0, 16'h0002}) begin
            n_fail++;
            $display("[TB] FAIL alarm_timeout: got %h expected %h", {state, alarm, blink, min_bcd, sec_bcd}, {3'd0, 1'b0, 1'b0, 16'h0002});
        end
        press(B_C);
        press(B_C);
        ticks(2);
        ticks(3);
        press(B_C);
        n_cmp++;
        if ({state, alarm, min_bcd, sec_bcd} !== {3'd0, 1'b0, 16'h0002}) begin
            n_fail++;
            $display("[TB] FAIL alarm_ack: got %h expected %h", {state, alarm, min_bcd, sec_bcd}, {3'd0, 1'b0, 16'h0002});
        end
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("[TB] FAIL alarm_model: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_pause();
        reset_dut();
        program_time(0, 30);
        press(B_C);
        applyStimulus(B_C, 1'b1);
        applyStimulus(B_NONE, 1'b0);
        n_cmp++;
        if ({state, min_bcd, sec_bcd} !== {3'd4, 16'h0030}) begin
            n_fail++;
            $display("[TB] FAIL pause_tick_lost: got %h expected %h", {state, min_bcd, sec_bcd}, {3'd4, 16'h0030});
        end
        ticks(5);
        n_cmp++;
        if ({state, min_bcd, sec_bcd} !== {3'd4, 16'h0030}) begin
            n_fail++;
            $display("[TB] FAIL pause_frozen: got %h expected %h", {state, min_bcd, sec_bcd}, {3'd4, 16'h0030});
        end
        press(B_C);
        ticks(1);
        n_cmp++;
        if ({state, min_bcd, sec_bcd} !== {3'd3, 16'h0029}) begin
            n_fail++;
            $display("[TB] FAIL pause_resume: got %h expected %h", {state, min_bcd, sec_bcd}, {3'd3, 16'h0029});
        end
    endtask

    task automatic test_zero_and_async_reset();
        reset_dut();
        press(B_C);
        press(B_C);
        n_cmp++;
        if ({state, min_bcd, sec_bcd} !== {3'd1, 16'h0000}) begin
            n_fail++;
            $display("[TB] FAIL zero_no_start: got %h expected %h", {state, min_bcd, sec_bcd}, {3'd1, 16'h0000});
        end
        program_time(0, 5);
        press(B_C);
        ticks(2);
        @(posedge clk);
        #7;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec !== 22'd0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %h expected %h", dut_vec, 22'd0);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        press(B_C);
        press(B_C);
        n_cmp++;
        if ({state, min_bcd, sec_bcd} !== {3'd1, 16'h0000}) begin
            n_fail++;
            $display("[TB] FAIL preset_lost: got %h expected %h", {state, min_bcd, sec_bcd}, {3'd1, 16'h0000});
        end
    endtask

    // One button level or tick per cycle; center may coincide with a tick.
    task automatic test_random();
        logic [4:0] b;
        logic t;
        int r;
        reset_dut();
        for (int i = 0; i < 2500; i++) begin
            r = int'($urandom_range(0, 11));
            b = B_NONE;
            t = 1'b0;
            if (r <= 4) b = 5'b00001 << r;
            else if (r >= 8 && r <= 10) t = 1'b1;
            else if (r == 11) begin b = B_C; t = 1'b1; end
            applyStimulus(b, t);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL random_%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic checkOutput();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_set_min();
        test_run();
        test_alarm();
        test_pause();
        test_zero_and_async_reset();
        test_random();
        checkOutput();
        $finish;
    end

endmodule
